spi_write_master: RTL and testbench

Single-channel SPI master that shifts one right-aligned word of up to 24 bits onto MOSI, MSB-first, and closes each word with a chip-select release and a latch-enable pulse. It sits directly downstream of the process controller. It is instantiated three times: ADF4002, LMX2594 and FPGA configuration. Each instance consumes that controller's per-channel `spi_start` bit plus the shared `spi_data_tx`, `spi_data_depth` and `spi_dir`, and returns its `spi_ready` bit.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_phase_timer.sv | 26 ++
 rtl/spi_write_master.sv | 132 +++++++++++++
 tb/tb_spi_write_master.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI write master
package spi_pkg;

    localparam int SPI_MAX_BITS = 24;
    localparam int SPI_DEPTH_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_LATCH
    } spi_state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - CLK_DIV-cycle phase down-counter with reload and end tick
module spi_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    output logic phase_end
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || reload) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign phase_end = (cnt == '0);

endmodule

// File: rtl/spi_write_master.sv
// rtl/spi_write_master.sv - mode-0 SPI master: one right-aligned word MSB-first, then CS release and LE pulse
module spi_write_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = SPI_MAX_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   dir,
    input  logic [DATA_W-1:0]      data_tx,
    input  logic [SPI_DEPTH_W-1:0] data_depth,
    output logic                   ready,
    output logic                   done,
    output logic [DATA_W-1:0]      rx_data,
    output logic                   sclk,
    output logic                   mosi,
    input  logic                   miso,
    output logic                   cs_n,
    output logic                   le
);

    localparam logic [SPI_DEPTH_W-1:0] DW = SPI_DEPTH_W'(DATA_W);

    spi_state_t             state;
    logic [DATA_W-1:0]      tx_sr;
    logic [DATA_W-1:0]      rx_sr;
    logic [4:0]             bit_cnt;
    logic                   dir_q;
    logic                   hi_first;
    logic                   phase_end;
    logic                   reload;
    logic                   accept;
    logic [SPI_DEPTH_W-1:0] eff_n;
    logic [DATA_W-1:0]      tx_aligned;

    // Word is left-justified at accept so MOSI always comes from the top bit.
    always_comb begin
        eff_n      = (data_depth > DW) ? DW : data_depth;
        tx_aligned = data_tx << (DW - eff_n);
    end

    assign accept = (state == ST_IDLE) && ready && start && (data_depth != '0);
    assign reload = (state == ST_IDLE) || phase_end;

    spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .reload    (reload),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ready    <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            le       <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            dir_q    <= 1'b0;
            hi_first <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_HIGH && hi_first) begin
                rx_sr    <= {rx_sr[DATA_W-2:0], miso};
                hi_first <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    ready <= 1'b1;
                    if (accept) begin
                        state   <= ST_SETUP;
                        ready   <= 1'b0;
                        cs_n    <= 1'b0;
                        sclk    <= 1'b0;
                        mosi    <= tx_aligned[DATA_W-1];
                        tx_sr   <= tx_aligned;
                        rx_sr   <= '0;
                        bit_cnt <= 5'(eff_n - 1'b1);
                        dir_q   <= dir;
                    end
                end
                ST_SETUP: if (phase_end) begin
                    state    <= ST_HIGH;
                    sclk     <= 1'b1;
                    hi_first <= 1'b1;
                end
                // Next bit goes out on the falling edge so it is settled a full phase before the rise.
                ST_HIGH: if (phase_end) begin
                    state <= ST_LOW;
                    sclk  <= 1'b0;
                    if (bit_cnt != '0) begin
                        tx_sr <= tx_sr << 1;
                        mosi  <= tx_sr[DATA_W-2];
                    end
                end
                ST_LOW: if (phase_end) begin
                    if (bit_cnt != '0) begin
                        bit_cnt  <= bit_cnt - 5'd1;
                        state    <= ST_HIGH;
                        sclk     <= 1'b1;
                        hi_first <= 1'b1;
                    end else begin
                        state <= ST_HOLD;
                        mosi  <= 1'b0;
                    end
                end
                ST_HOLD: if (phase_end) begin
                    state <= ST_LATCH;
                    cs_n  <= 1'b1;
                    le    <= 1'b1;
                end
                ST_LATCH: if (phase_end) begin
                    state <= ST_IDLE;
                    le    <= 1'b0;
                    done  <= 1'b1;
                    ready <= 1'b1;
                    if (dir_q) rx_data <= rx_sr;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_write_master.sv
// tb/tb_spi_write_master.sv - randomized self-checking bench for spi_write_master
module tb_spi_write_master;

    localparam int D  = 4;
    localparam int DW = 24;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, dir = 1'b0, miso = 1'b0;
    logic [23:0] data_tx = '0;
    logic [7:0]  data_depth = '0;
    logic        ready, done, sclk, mosi, cs_n, le;
    logic [23:0] rx_data;

    logic        start1 = 1'b0, miso1 = 1'b0;
    logic [23:0] data_tx1 = '0;
    logic [7:0]  depth1 = '0;
    logic        ready1, done1, sclk1, mosi1, cs_n1, le1;
    logic [23:0] rx1;

    spi_write_master #(.CLK_DIV(D), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .data_tx(data_tx),
        .data_depth(data_depth), .ready(ready), .done(done), .rx_data(rx_data),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n), .le(le));

    spi_write_master #(.CLK_DIV(1), .DATA_W(DW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dir(1'b0), .data_tx(data_tx1),
        .data_depth(depth1), .ready(ready1), .done(done1), .rx_data(rx1),
        .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1), .le(le1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;

    bit          mosi_q[$];
    logic [23:0] mi_word = '0;
    int          mi_idx = 0;
    always @(posedge sclk) mosi_q.push_back(mosi);
    always @(negedge sclk) if (mi_idx > 0) begin mi_idx--; miso = mi_word[mi_idx]; end

    int   n_rise1 = 0;
    logic mosi1_at = 1'b0;
    always @(posedge sclk1) begin n_rise1++; mosi1_at = mosi1; end

    int          o_t0, o_cs_first, o_cs_len, o_le_len, o_done_at, o_ndone, o_nbits;
    logic [23:0] o_rx, exp_rx;
    logic [31:0] o_bits;

    // Observation indices follow "cycle T0+k" = outputs after accept edge T0 advanced k-1 more edges.
    task automatic do_xfer(input logic [23:0] d, input int dep, input logic dr,
                           input logic [23:0] mw, input bit hold_start);
        int n;
        bit fin;
        n = (dep > DW) ? DW : dep;
        for (int k = 0; k < 200 && ready !== 1'b1; k++) @(negedge clk);
        data_tx = d; data_depth = 8'(dep); dir = dr; start = 1'b1;
        mosi_q.delete(); mi_word = mw; mi_idx = n - 1; miso = mw[n-1];
        o_t0 = cyc + 1; o_cs_first = -1; o_cs_len = 0; o_le_len = 0;
        o_done_at = -1; o_ndone = 0; o_rx = 'x; fin = 0;
        for (int k = 0; k < 2000 && !fin; k++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            else if (ready !== 1'b1) data_tx = 24'($urandom);
            if (cs_n === 1'b0) begin
                if (o_cs_first < 0) o_cs_first = cyc + 1;
                o_cs_len++;
            end
            if (le === 1'b1) o_le_len++;
            if (done === 1'b1) begin o_ndone++; o_done_at = cyc + 1; o_rx = rx_data; fin = 1; end
        end
        o_bits = '0;
        foreach (mosi_q[i]) o_bits = {o_bits[30:0], mosi_q[i]};
        o_nbits = mosi_q.size();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if ({ready, done, sclk, mosi, cs_n, le} !== 6'b000010) begin n_fail++; $display("FAIL reset_outputs got %b exp 000010", {ready, done, sclk, mosi, cs_n, le}); end
        n_tests++; if (rx_data !== 24'h0) begin n_fail++; $display("FAIL reset_rx got %h exp 000000", rx_data); end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise got %b exp 1", ready); end
        exp_rx = '0;
    endtask

    task automatic test_basic();
        do_xfer(24'h1F8093, 24, 1'b0, 24'hFFFFFF, 1'b0);
        n_tests++; if (o_bits !== 32'h001F8093) begin n_fail++; $display("FAIL basic_mosi got %h exp 001f8093", o_bits); end
        n_tests++; if (o_nbits !== 24) begin n_fail++; $display("FAIL basic_rises got %0d exp 24", o_nbits); end
        n_tests++; if (o_cs_first !== o_t0 + 1 || o_cs_len !== 200) begin n_fail++; $display("FAIL basic_cs got first %0d len %0d exp %0d 200", o_cs_first, o_cs_len, o_t0 + 1); end
        n_tests++; if (o_le_len !== 4) begin n_fail++; $display("FAIL basic_le got %0d exp 4", o_le_len); end
        n_tests++; if (o_done_at !== o_t0 + 205 || o_ndone !== 1) begin n_fail++; $display("FAIL basic_done got %0d exp %0d", o_done_at, o_t0 + 205); end
        n_tests++; if (o_rx !== exp_rx) begin n_fail++; $display("FAIL basic_rx_hold got %h exp %h", o_rx, exp_rx); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] d;
        int idle_bad;
        for (int i = 0; i < 3; i++) begin
            d = 24'($urandom);
            do_xfer(d, 8, 1'b0, 24'h0, i < 2);
            n_tests++; if (o_bits !== {24'h0, d[7:0]} || o_ndone !== 1) begin n_fail++; $display("FAIL b2b_frame%0d got %h exp %h", i, o_bits, d[7:0]); end
            n_tests++; if (o_cs_first !== o_t0 + 1 || o_done_at !== o_t0 + 1 + 19 * D) begin n_fail++; $display("FAIL b2b_timing%0d got cs %0d done %0d exp %0d %0d", i, o_cs_first, o_done_at, o_t0 + 1, o_t0 + 1 + 19 * D); end
        end
        idle_bad = 0;
        repeat (40) begin @(negedge clk); if (cs_n !== 1'b1 || ready !== 1'b1 || done !== 1'b0) idle_bad++; end
        n_tests++; if (idle_bad !== 0) begin n_fail++; $display("FAIL b2b_extra_frame got %0d busy cycles exp 0", idle_bad); end
    endtask

    task automatic test_capture();
        do_xfer(24'($urandom), 8, 1'b1, 24'h0000A5, 1'b0);
        exp_rx = 24'h0000A5;
        n_tests++; if (o_rx !== 24'h0000A5) begin n_fail++; $display("FAIL capture_rx got %h exp 0000a5", o_rx); end
        do_xfer(24'($urandom), 12, 1'b0, 24'($urandom), 1'b0);
        n_tests++; if (o_rx !== 24'h0000A5 || rx_data !== 24'h0000A5) begin n_fail++; $display("FAIL capture_hold got %h exp 0000a5", o_rx); end
    endtask

    task automatic test_depth_edges();
        logic [23:0] d, mw;
        int busy;
        for (int k = 0; k < 200 && ready !== 1'b1; k++) @(negedge clk);
        data_depth = 8'd0; data_tx = 24'hFFFFFF; start = 1'b1; busy = 0;
        repeat (20) begin @(negedge clk); if (cs_n !== 1'b1 || ready !== 1'b1 || done !== 1'b0 || sclk !== 1'b0) busy++; end
        start = 1'b0;
        n_tests++; if (busy !== 0) begin n_fail++; $display("FAIL depth0_ignored got %0d busy cycles exp 0", busy); end
        d = 24'($urandom); mw = 24'($urandom);
        do_xfer(d, 40, 1'b1, mw, 1'b0);
        exp_rx = mw;
        n_tests++; if (o_nbits !== 24 || o_bits !== {8'h0, d}) begin n_fail++; $display("FAIL depth40_bits got %0d bits %h exp 24 %h", o_nbits, o_bits, d); end
        n_tests++; if (o_done_at !== o_t0 + 1 + 51 * D || o_rx !== mw) begin n_fail++; $display("FAIL depth40_done got %0d rx %h exp %0d %h", o_done_at, o_rx, o_t0 + 1 + 51 * D, mw); end
    endtask

    task automatic test_random();
        logic [23:0] d, mw;
        logic [31:0] mask;
        logic        dr;
        int          dep, n;
        for (int i = 0; i < 6; i++) begin
            d = 24'($urandom); mw = 24'($urandom); dr = 1'($urandom);
            dep = $urandom_range(1, 30);
            n = (dep > DW) ? DW : dep;
            mask = (32'h1 << n) - 32'h1;
            do_xfer(d, dep, dr, mw, 1'b0);
            if (dr) exp_rx = 24'({8'h0, mw} & mask);
            n_tests++; if (o_bits !== ({8'h0, d} & mask) || o_nbits !== n) begin n_fail++; $display("FAIL rand%0d_mosi got %h/%0d exp %h/%0d", i, o_bits, o_nbits, {8'h0, d} & mask, n); end
            n_tests++; if (o_cs_len !== (2 * n + 2) * D || o_le_len !== D) begin n_fail++; $display("FAIL rand%0d_frame got cs %0d le %0d exp %0d %0d", i, o_cs_len, o_le_len, (2 * n + 2) * D, D); end
            n_tests++; if (o_done_at !== o_t0 + 1 + (2 * n + 3) * D || o_ndone !== 1) begin n_fail++; $display("FAIL rand%0d_done got %0d exp %0d", i, o_done_at, o_t0 + 1 + (2 * n + 3) * D); end
            n_tests++; if (o_rx !== exp_rx) begin n_fail++; $display("FAIL rand%0d_rx got %h exp %h", i, o_rx, exp_rx); end
        end
    endtask

    task automatic test_mid_reset();
        int seen_done;
        for (int k = 0; k < 200 && ready !== 1'b1; k++) @(negedge clk);
        mosi_q.delete(); mi_idx = 0;
        data_tx = 24'($urandom); data_depth = 8'd24; dir = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; seen_done = 0;
        for (int k = 0; k < 500 && mosi_q.size() < 10; k++) begin @(negedge clk); if (done === 1'b1) seen_done++; end
        n_tests++; if (mosi_q.size() !== 10 || cs_n !== 1'b0) begin n_fail++; $display("FAIL midrst_reach got %0d bits cs_n %b exp 10 0", mosi_q.size(), cs_n); end
        rst_n = 1'b0;
        @(negedge clk);
        if (done === 1'b1) seen_done++;
        n_tests++; if ({cs_n, sclk, le, ready} !== 4'b1000) begin n_fail++; $display("FAIL midrst_outputs got %b exp 1000", {cs_n, sclk, le, ready}); end
        rst_n = 1'b1;
        @(negedge clk);
        if (done === 1'b1) seen_done++;
        exp_rx = '0;
        n_tests++; if (ready !== 1'b1 || rx_data !== exp_rx || seen_done !== 0) begin n_fail++; $display("FAIL midrst_release got ready %b rx %h dones %0d exp 1 000000 0", ready, rx_data, seen_done); end
    endtask

    task automatic test_clkdiv1();
        int t0, done_at, cs_len;
        for (int k = 0; k < 50 && ready1 !== 1'b1; k++) @(negedge clk);
        n_rise1 = 0; data_tx1 = 24'h000001; depth1 = 8'd1; start1 = 1'b1;
        t0 = cyc + 1; done_at = -1; cs_len = 0;
        for (int k = 0; k < 50 && done_at < 0; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (cs_n1 === 1'b0) cs_len++;
            if (done1 === 1'b1) done_at = cyc + 1;
        end
        n_tests++; if (done_at !== t0 + 6) begin n_fail++; $display("FAIL div1_done got %0d exp %0d", done_at, t0 + 6); end
        n_tests++; if (cs_len !== 4 || n_rise1 !== 1 || mosi1_at !== 1'b1) begin n_fail++; $display("FAIL div1_frame got cs %0d rises %0d bit %b exp 4 1 1", cs_len, n_rise1, mosi1_at); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_capture();
        test_depth_edges();
        test_random();
        test_mid_reset();
        test_clkdiv1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
